// File: rtl/rb_osc_pkg.sv
// Shared types and constants for the RadioBox modulated DDS oscillator core.
package rb_osc_pkg;

  typedef enum logic [1:0] {
    RB_MOD_NONE = 2'd0,
    RB_MOD_FM   = 2'd1,
    RB_MOD_PM   = 2'd2,
    RB_MOD_AM   = 2'd3
  } rb_mod_mode_t;

  // Capture-edge to osc_o latencies for each input class.
  localparam int LAT_PM = 5;
  localparam int LAT_AM = 5;
  localparam int LAT_FM = 6;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1, right-shifting Galois form

endpackage

// File: rtl/rb_osc_qsin_rom.sv
// Quarter-wave sine table, first quadrant sampled at half-index points.
// Registered read, 1-cycle latency, synchronous active-low clear.
module rb_osc_qsin_rom
  import rb_osc_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 16
) (
  input  logic              clk_adc_125mhz,
  input  logic              adc_rstn_i,
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-1:0]  data
);

  localparam int  DEPTH = 1 << LUT_AW;
  localparam real AMP   = real'((1 << (OUT_W - 1)) - 1);
  localparam real PI    = 3.14159265358979323846;

  logic [OUT_W-1:0] tbl [DEPTH];

  // Half-index offset keeps the quadrant fold symmetric without duplicate end points.
  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    assign tbl[i] = OUT_W'($rtoi(AMP * $sin(PI * (real'(i) + 0.5) / real'(2 * DEPTH)) + 0.5));
  end

  always_ff @(posedge clk_adc_125mhz) begin
    if (!adc_rstn_i) data <= '0;
    else             data <= tbl[addr];
  end

endmodule

// File: rtl/rb_osc_mod_core.sv
// DDS oscillator with per-sample FM/PM/AM: S0 capture, S1 accumulate, S2 phase, S3 fold, S4 ROM, S5 sign, S6 amplitude.
// Optional phase dithering when RB_OSC_DITHER_EN is defined.
module rb_osc_mod_core
  import rb_osc_pkg::*;
#(
  parameter int PHASE_W = 48,
  parameter int LUT_AW  = 10,
  parameter int OUT_W   = 16,
  parameter int MOD_W   = 16,
  parameter int FM_SHL  = 32
) (
  input  logic                     clk_adc_125mhz,
  input  logic                     adc_rstn_i,
  input  logic                     osc_en_i,
  input  logic                     osc_resync_i,
  input  logic [PHASE_W-1:0]       osc_inc_i,
  input  logic [PHASE_W-1:0]       osc_ofs_i,
  input  logic [1:0]               mod_mode_i,
  input  logic signed [MOD_W-1:0]  mod_i,
  output logic signed [OUT_W-1:0]  osc_o,
  output logic                     osc_valid_o,
  output logic                     osc_wrap_o
);

  localparam int TOP_W = LUT_AW + 2;

  // S0
  logic               en0, resync0;
  logic [PHASE_W-1:0] inc0, ofs0;
  rb_mod_mode_t       mode0;
  logic signed [MOD_W-1:0] mod0;

  // S1..S5 datapath and side-band pipeline
  logic [PHASE_W-1:0] acc;
  logic               v1, v2, v3, v4, v5;
  logic [TOP_W-1:0]   ph;
  logic [LUT_AW-1:0]  addr3;
  logic               neg3, neg4;
  logic [OUT_W-1:0]   rom_q;
  logic signed [OUT_W-1:0] s5;
  rb_mod_mode_t       mode2, mode3, mode4, mode5;
  logic signed [MOD_W-1:0] mod2, mod3, mod4, mod5;

  logic [PHASE_W-1:0] mod_ext, inc_eff, pm_term, dith, ph_next;
  logic [PHASE_W:0]   sum;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  idx;
  logic signed [OUT_W+MOD_W-1:0] prod;
  logic               bits_unused;

  always_ff @(posedge clk_adc_125mhz) begin
    if (!adc_rstn_i) begin
      en0     <= 1'b0;
      resync0 <= 1'b0;
      inc0    <= '0;
      ofs0    <= '0;
      mode0   <= RB_MOD_NONE;
      mod0    <= '0;
    end else begin
      en0     <= osc_en_i;
      resync0 <= osc_resync_i;
      inc0    <= osc_inc_i;
      ofs0    <= osc_ofs_i;
      mode0   <= rb_mod_mode_t'(mod_mode_i);
      mod0    <= mod_i;
    end
  end

  always_comb begin
    mod_ext = {{(PHASE_W-MOD_W){mod0[MOD_W-1]}}, mod0};
    inc_eff = inc0;
    pm_term = '0;
    if (mode0 == RB_MOD_FM) inc_eff = inc0 + (mod_ext << FM_SHL);
    if (mode0 == RB_MOD_PM) pm_term = {mod0, {(PHASE_W-MOD_W){1'b0}}};
    sum     = {1'b0, acc} + {1'b0, inc_eff};
    ph_next = acc + ofs0 + pm_term + dith;
    quad    = ph[TOP_W-1 -: 2];
    idx     = ph[LUT_AW-1:0];
    prod    = s5 * mod5;
  end

`ifdef RB_OSC_DITHER_EN
  if (PHASE_W - 2 - LUT_AW < 16) begin : g_dither_width_check
    $error("rb_osc_mod_core: dithering needs PHASE_W-2-LUT_AW >= 16");
  end

  logic [15:0] lfsr;

  always_ff @(posedge clk_adc_125mhz) begin
    if (!adc_rstn_i) lfsr <= LFSR_SEED;
    else if (v1)     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  // Dither spans strictly less than one table step.
  assign dith = PHASE_W'(lfsr) << (PHASE_W - 2 - LUT_AW - 16);
`else
  assign dith = '0;
`endif

  always_ff @(posedge clk_adc_125mhz) begin
    if (!adc_rstn_i) begin
      acc        <= '0;
      osc_wrap_o <= 1'b0;
      v1         <= 1'b0;
    end else begin
      v1 <= en0;
      if (resync0) begin
        acc        <= '0;
        osc_wrap_o <= 1'b0;
      end else if (en0) begin
        acc        <= sum[PHASE_W-1:0];
        osc_wrap_o <= sum[PHASE_W];
      end else begin
        osc_wrap_o <= 1'b0;
      end
    end
  end

  // S2 phase feeds only the fold, so just the quadrant and index bits are kept.
  always_ff @(posedge clk_adc_125mhz) begin
    if (!adc_rstn_i) begin
      ph    <= '0;
      v2    <= 1'b0;
      mode2 <= RB_MOD_NONE;
      mod2  <= '0;
      addr3 <= '0;
      neg3  <= 1'b0;
      v3    <= 1'b0;
      mode3 <= RB_MOD_NONE;
      mod3  <= '0;
      neg4  <= 1'b0;
      v4    <= 1'b0;
      mode4 <= RB_MOD_NONE;
      mod4  <= '0;
      s5    <= '0;
      v5    <= 1'b0;
      mode5 <= RB_MOD_NONE;
      mod5  <= '0;
    end else begin
      ph    <= ph_next[PHASE_W-1 -: TOP_W];
      v2    <= v1;
      mode2 <= mode0;
      mod2  <= mod0;
      addr3 <= quad[0] ? ~idx : idx;
      neg3  <= quad[1];
      v3    <= v2;
      mode3 <= mode2;
      mod3  <= mod2;
      neg4  <= neg3;
      v4    <= v3;
      mode4 <= mode3;
      mod4  <= mod3;
      s5    <= neg4 ? -rom_q : rom_q;
      v5    <= v4;
      mode5 <= mode4;
      mod5  <= mod4;
    end
  end

  rb_osc_qsin_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_rom (
    .clk_adc_125mhz (clk_adc_125mhz),
    .adc_rstn_i     (adc_rstn_i),
    .addr           (addr3),
    .data           (rom_q)
  );

  // The slice of prod is (s*m)>>>(MOD_W-1) truncated; |s| < 2^(OUT_W-1) so it cannot overflow.
  always_ff @(posedge clk_adc_125mhz) begin
    if (!adc_rstn_i) begin
      osc_o       <= '0;
      osc_valid_o <= 1'b0;
    end else begin
      osc_valid_o <= v5;
      if (!v5)                     osc_o <= '0;
      else if (mode5 == RB_MOD_AM) osc_o <= prod[MOD_W-1 +: OUT_W];
      else                         osc_o <= s5;
    end
  end

  assign bits_unused = ^{ph_next[PHASE_W-TOP_W-1:0], prod[OUT_W+MOD_W-1], prod[MOD_W-2:0]};

endmodule

// File: tb/tb_rb_osc_mod_core.sv
// Directed vector bench for rb_osc_mod_core (default build, no dithering).
module tb_rb_osc_mod_core;
  import rb_osc_pkg::*;

  logic               clk = 1'b0;
  logic               rstn;
  logic               en, resync;
  logic [47:0]        inc, ofs;
  logic [1:0]         mode;
  logic signed [15:0] mod;
  logic signed [15:0] osc;
  logic               valid, wrap;

  int nvec = 0;
  int nmis = 0;

  localparam logic [47:0] P44 = 48'h1 << 44;
  localparam logic [47:0] P46 = 48'h1 << 46;
  localparam logic [47:0] P47 = 48'h1 << 47;

  always #4 clk = ~clk;

  rb_osc_mod_core dut (
    .clk_adc_125mhz (clk),
    .adc_rstn_i     (rstn),
    .osc_en_i       (en),
    .osc_resync_i   (resync),
    .osc_inc_i      (inc),
    .osc_ofs_i      (ofs),
    .mod_mode_i     (mode),
    .mod_i          (mod),
    .osc_o          (osc),
    .osc_valid_o    (valid),
    .osc_wrap_o     (wrap)
  );

  typedef struct {
    string       name;
    logic        en;
    logic [47:0] ofs;
    logic [1:0]  mode;
    logic [15:0] mod;
    int          exp_o;
    logic        exp_v;
  } vec_t;

  vec_t vecs[14];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; resync = 1'b0; inc = '0; ofs = '0;
    mode = RB_MOD_NONE; mod = '0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic count_wraps(input int cycles, output int cnt, output int bad_gap, input int gap);
    int last;
    cnt = 0; bad_gap = 0; last = -1;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (wrap) begin
        if (last >= 0 && (i - last) != gap) bad_gap++;
        last = i;
        cnt++;
      end
    end
  endtask

  initial begin
    int cnt, bad, first;
    int samp[32];

    vecs[0]  = '{"static_q0",    1'b1, 48'h0,   RB_MOD_NONE, 16'h0000,     25, 1'b1};
    vecs[1]  = '{"static_q1",    1'b1, P46,     RB_MOD_NONE, 16'h0000,  32767, 1'b1};
    vecs[2]  = '{"static_q2",    1'b1, P47,     RB_MOD_NONE, 16'h0000,    -25, 1'b1};
    vecs[3]  = '{"static_q3",    1'b1, P46+P47, RB_MOD_NONE, 16'h0000, -32767, 1'b1};
    vecs[4]  = '{"pm_quarter",   1'b1, 48'h0,   RB_MOD_PM,   16'h4000,  32767, 1'b1};
    vecs[5]  = '{"pm_half",      1'b1, 48'h0,   RB_MOD_PM,   16'h8000,    -25, 1'b1};
    vecs[6]  = '{"pm_plus_ofs",  1'b1, P46,     RB_MOD_PM,   16'h4000,    -25, 1'b1};
    vecs[7]  = '{"am_half",      1'b1, P46,     RB_MOD_AM,   16'h4000,  16383, 1'b1};
    vecs[8]  = '{"am_negfull",   1'b1, P46,     RB_MOD_AM,   16'h8000, -32767, 1'b1};
    vecs[9]  = '{"am_zero",      1'b1, P46,     RB_MOD_AM,   16'h0000,      0, 1'b1};
    vecs[10] = '{"am_neg_floor", 1'b1, P47,     RB_MOD_AM,   16'h4000,    -13, 1'b1};
    vecs[11] = '{"disabled",     1'b0, P46,     RB_MOD_NONE, 16'h0000,      0, 1'b0};
    vecs[12] = '{"fm_zero_mod",  1'b1, P46,     RB_MOD_FM,   16'h0000,  32767, 1'b1};
    vecs[13] = '{"none_ign_mod", 1'b1, 48'h0,   RB_MOD_NONE, 16'h4000,     25, 1'b1};

    // Reset state
    rstn = 1'b0; en = 1'b0; resync = 1'b0; inc = '0; ofs = '0; mode = RB_MOD_NONE; mod = '0;
    tick(1);
    check("reset_osc", osc, 0);
    check("reset_valid", valid, 0);
    check("reset_wrap", wrap, 0);
    rstn = 1'b1;
    tick(1);

    // en -> valid latency is 6 edges from capture
    en = 1'b1; ofs = P46;
    tick(6);
    check("valid_lat_early", valid, 0);
    tick(1);
    check("valid_lat", valid, 1);
    check("valid_lat_osc", osc, 32767);

    // ofs latency 5
    ofs = 48'h0;
    tick(8);
    ofs = P46;
    tick(5);
    check("ofs_lat_early", osc, 25);
    tick(1);
    check("ofs_lat", osc, 32767);

    // inc latency 6: one-cycle increment pulse moves acc by a quarter turn
    ofs = 48'h0;
    tick(8);
    inc = P46;
    tick(1);
    inc = '0;
    tick(5);
    check("inc_lat_early", osc, 25);
    tick(1);
    check("inc_lat", osc, 32767);

    // Static table, accumulator parked at zero
    do_reset();
    for (int i = 0; i < 14; i++) begin
      en = vecs[i].en; ofs = vecs[i].ofs; mode = vecs[i].mode; mod = vecs[i].mod;
      tick(8);
      check({vecs[i].name, "_osc"}, osc, vecs[i].exp_o);
      check({vecs[i].name, "_valid"}, valid, vecs[i].exp_v);
    end

    // Frequency and wrap, mode NONE
    do_reset();
    en = 1'b1; inc = P44; ofs = 48'h0; mode = RB_MOD_NONE; mod = '0;
    tick(10);
    for (int i = 0; i < 32; i++) begin
      tick(1);
      samp[i] = osc;
    end
    check("period16_repeat", samp[20], samp[4]);
    check("period16_half_neg", samp[11], -samp[3]);
    count_wraps(64, cnt, bad, 16);
    check("wrap16_count", cnt, 4);
    check("wrap16_gap", bad, 0);

    // FM doubles the rate
    mode = RB_MOD_FM; mod = 16'sd4096;
    tick(4);
    count_wraps(64, cnt, bad, 8);
    check("fm_wrap8_count", cnt, 8);
    check("fm_wrap8_gap", bad, 0);

    // FM cancels the increment: frozen accumulator
    mod = -16'sd4096;
    tick(8);
    first = osc;
    count_wraps(40, cnt, bad, 1);
    check("fm_frozen_wraps", cnt, 0);
    check("fm_frozen_osc", osc, first);

    // Resync holds acc at 0
    mode = RB_MOD_NONE; mod = '0; ofs = P46; resync = 1'b1;
    tick(2);
    count_wraps(8, cnt, bad, 1);
    check("resync_no_wrap", cnt, 0);
    check("resync_phase", osc, 32767);
    resync = 1'b0;
    tick(1);
    first = -1;
    for (int i = 1; i <= 40 && first < 0; i++) begin
      tick(1);
      if (wrap) first = i;
    end
    check("resync_first_wrap", first, 16);

    // Reset mid-run aborts everything
    tick(3);
    rstn = 1'b0;
    tick(1);
    check("midreset_osc", osc, 0);
    check("midreset_valid", valid, 0);
    check("midreset_wrap", wrap, 0);
    rstn = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/rb_osc_mod_core.md
# rb_osc_mod_core

Parametrised DDS oscillator core with per-sample AM/FM/PM modulation: a phase accumulator, a quarter-wave sine lookup and an amplitude stage in one fixed-latency pipeline. It is the next-generation oscillator used by the RadioBox: one instance per OSC slot, with register values supplied by the RadioBox register file and the output feeding the RadioBox mixer/DAC path. Compared with the fixed OSC1/OSC2 pair, it adds parametrised phase, output and modulation widths, an input-driven modulation mode, a wrap strobe and optional phase dithering.

## Interface
- PHASE_W, 48: phase accumulator, increment and offset width.
- LUT_AW, 10: quarter-wave table address width (2^LUT_AW entries).
- OUT_W, 16: signed sine output width.
- MOD_W, 16: signed modulation input width.
- FM_SHL, 32: left shift that scales mod_i into increment units for FM.

Ports (widths are the parameter defaults):
- clk_adc_125mhz  in  1  ADC clock, 125 MHz
- adc_rstn_i  in  1  synchronous, active-low reset
- osc_en_i  in  1  accumulator advance enable
- osc_resync_i  in  1  holds the accumulator at 0 while high
- osc_inc_i  in  PHASE_W  phase increment, unsigned
- osc_ofs_i  in  PHASE_W  phase offset, unsigned
- mod_mode_i  in  2  0 NONE, 1 FM, 2 PM, 3 AM
- mod_i  in  MOD_W  signed modulation sample, taken every cycle
- osc_o  out  OUT_W  signed oscillator output
- osc_valid_o  out  1  osc_o carries live data
- osc_wrap_o  out  1  one-cycle pulse when the accumulator wraps

## Operation
The pipeline has seven stages, S0 to S6.
- **S0:** registers every input except the clock and reset.
- **S1, accumulator:**
  - If resync is high: acc←0 and no wrap pulse.
  - Else if en is high: acc←acc+inc_eff. inc_eff is inc, or in FM mode inc + (sext(mod)<<FM_SHL). The addition is modulo 2^PHASE_W.
  - Else: acc holds.
  - osc_wrap_o is the registered carry-out of that addition.
- **S2, phase:** ph←acc+ofs+pm, modulo 2^PHASE_W. pm is sext(mod)<<(PHASE_W−MOD_W) in PM mode (full scale is ±half a turn); otherwise pm is 0.
- **S3, fold:**
  - Quadrant q = ph[PHASE_W−1:PHASE_W−2].
  - Index idx = ph[PHASE_W−3 -: LUT_AW].
  - The table address is idx for q=0 or 2, and ~idx for q=1 or 3.
  - The negate flag is q[1].
- **S4, ROM:** registered read. Entry i = round((2^(OUT_W−1)−1)·sin(π/2·(i+0.5)/2^LUT_AW)). For the defaults, entry 0 is 25 and entry 1023 is 32767.
- **S5, sign:** s = negate ? −rom : rom.
- **S6, amplitude:**
  - In AM mode: osc_o = (s·m)>>>(MOD_W−1), arithmetic and truncating. m is the AM mod sample delayed to align with the same S0 sample. No saturation is needed because |s| ≤ 2^(OUT_W−1)−1.
  - In other modes: osc_o = s.
- **Validity:** the en bit travels down the pipeline alongside the data. When the delayed en is 0, osc_o is 0 and osc_valid_o is 0.
- **Simultaneous events and mode changes:**
  - If resync and en are both high, resync wins.
  - If resync is high and en is low, acc is cleared.
  - A mode change takes effect per sample along the pipeline, with no glitch suppression.

## Timing
- **Reset:** one rising edge with adc_rstn_i=0 clears every register. osc_o=0, osc_valid_o=0, osc_wrap_o=0, acc=0; the ROM output register is also cleared. A reset mid-operation aborts all samples in flight.
- **Latency from the S0 capture edge to osc_o** (constants in the package):
  - ofs, PM mod and AM mod: 5 cycles (LAT_PM, LAT_AM).
  - inc and FM mod: 6 cycles (LAT_FM).
  - en to osc_valid_o: 6 cycles.
- **Resync release:** on the first edge after resync is sampled low, acc = inc_eff. The S2 phase computed from the last held value equals ofs exactly.
- **Throughput:** one sample per clock. There is no back-pressure.

## Configuration
- Macro: RB_OSC_DITHER_EN.
- **With the macro:**
  - A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), seeded with 0xACE1 at reset, advances every cycle that S2 is valid.
  - Its value, shifted left by (PHASE_W−2−LUT_AW−16), is added into ph at S2.
  - This requires PHASE_W−2−LUT_AW ≥ 16, enforced by an elaboration-time assertion.
- **Without the macro:** no LFSR is built and the output is bit-exact deterministic.

## Structure
- **Package rb_osc_pkg:**
  - The rb_mod_mode_t enum: RB_MOD_NONE, RB_MOD_FM, RB_MOD_PM, RB_MOD_AM.
  - The constants LAT_PM, LAT_FM, LAT_AM.
  - The LFSR seed and taps.
- **Sub-module rb_osc_qsin_rom:**
  - A quarter-wave table parametrised by LUT_AW and OUT_W.
  - Registered read with 1-cycle latency.
  - Synchronous clear on adc_rstn_i.

## Test plan
Build without RB_OSC_DITHER_EN unless noted.
- **Static phase:** en=1, inc=0, mode NONE, ofs = 0 / 2^46 / 2^47 / 3·2^46 → osc_o = 25 / 32767 / −25 / −32767, with osc_valid_o high 6 cycles after en rises.
- **Frequency and wrap:** inc=2^44, mode NONE → osc_o period is 16 cycles and osc_wrap_o pulses every 16 cycles. Asserting resync for 10 cycles gives no wrap pulses, and after release the first S2 phase equals ofs.
- **FM:** inc=2^44, mode FM, mod=4096 → period 8 cycles and wrap every 8 cycles. With mod=−4096 → acc frozen, no wrap.
- **PM:** inc=0, ofs=0, mode PM, mod=0x4000 → osc_o=32767 5 cycles after the capture edge. mod=0x8000 → −25.
- **AM:** inc=0, ofs=2^46, mode AM, mod=0x4000 → osc_o=16383. mod=0x8000 → −32767. mod=0 → 0.
- **Reset and dither:**
  - Reset mid-run (sync low for 1 edge) → all outputs 0 on the next cycle.
  - With RB_OSC_DITHER_EN, static ofs=2^46 → osc_o stays within entries 1022..1023 (≥ 32766).
